// File: rtl/nx_node_instr_store.sv
// Instruction store: loader writes pass through a small FIFO into a single-port RAM shared with core fetches.
// Optional build macro NX_INSTR_STORE_BYPASS_EN lets reads that hit buffered writes take the youngest data without stalling.
module nx_node_instr_store #(
  parameter int RAM_ADDR_W       = 10,
  parameter int RAM_DATA_W       = 32,
  parameter int WR_FIFO_DEPTH    = 4,
  parameter int NODE_PARAM_WIDTH = RAM_ADDR_W + 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [RAM_ADDR_W-1:0]       i_wr_addr,
  input  logic [RAM_DATA_W-1:0]       i_wr_data,
  input  logic                        i_wr_valid,
  output logic                        o_wr_ready,
  input  logic [RAM_ADDR_W-1:0]       i_rd_addr,
  input  logic                        i_rd_en,
  output logic [RAM_DATA_W-1:0]       o_rd_data,
  output logic                        o_rd_stall,
  output logic [NODE_PARAM_WIDTH-1:0] o_populated,
  output logic                        o_wr_pending
);

  localparam int PTR_W = $clog2(WR_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [RAM_ADDR_W-1:0]       fifo_addr_q [WR_FIFO_DEPTH];
  logic [RAM_DATA_W-1:0]       fifo_data_q [WR_FIFO_DEPTH];
  logic [RAM_DATA_W-1:0]       mem [2**RAM_ADDR_W];

  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [RAM_DATA_W-1:0]       rd_data_q, rd_data_d;
  logic [NODE_PARAM_WIDTH-1:0] populated_q, populated_d, head_top;

  logic                        full, empty, push, pop, ram_rd, byp, stall, hit;
  logic [PTR_W-1:0]            hit_idx;
  logic [RAM_DATA_W-1:0]       hit_data;

  assign full  = (count_q == CNT_W'(WR_FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = i_wr_valid && !full;

  // Scan from head to tail so the last match is the youngest write.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    hit_idx  = '0;
    for (int k = 0; k < WR_FIFO_DEPTH; k++) begin
      hit_idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (fifo_addr_q[hit_idx] == i_rd_addr)) begin
        hit      = 1'b1;
        hit_data = fifo_data_q[hit_idx];
      end
    end
  end

  always_comb begin
    pop    = 1'b0;
    ram_rd = 1'b0;
    byp    = 1'b0;
    stall  = 1'b0;
    if (i_rd_en && full) begin
      pop   = 1'b1;
      stall = 1'b1;
    end else if (i_rd_en && hit) begin
      pop = 1'b1;
`ifdef NX_INSTR_STORE_BYPASS_EN
      byp = 1'b1;
`else
      stall = 1'b1;
`endif
    end else if (i_rd_en) begin
      ram_rd = 1'b1;
    end else if (!empty) begin
      pop = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_data_d   = rd_data_q;
    if (byp) begin
      rd_data_d = hit_data;
    end else if (ram_rd) begin
      rd_data_d = mem[i_rd_addr];
    end
    head_top    = NODE_PARAM_WIDTH'(fifo_addr_q[rd_ptr_q]) + NODE_PARAM_WIDTH'(1);
    populated_d = populated_q;
    if (pop && (head_top > populated_q)) begin
      populated_d = head_top;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      populated_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      populated_q <= populated_d;
    end
  end

  // Buffer payload and RAM contents carry no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= i_wr_addr;
      fifo_data_q[wr_ptr_q] <= i_wr_data;
    end
    if (pop) begin
      mem[fifo_addr_q[rd_ptr_q]] <= fifo_data_q[rd_ptr_q];
    end
  end

  assign o_wr_ready   = !full;
  assign o_wr_pending = !empty;
  assign o_rd_stall   = stall;
  assign o_rd_data    = rd_data_q;
  assign o_populated  = populated_q;

endmodule

// File: tb/tb_nx_node_instr_store.sv
// Scoreboard bench for nx_node_instr_store: read data is queued at issue and checked by a monitor one cycle after acceptance.
module tb_nx_node_instr_store;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int PW = AW + 1;
  localparam logic [DW-1:0] BG = 32'h0000C8C8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_stall;
  logic [PW-1:0] populated;
  logic          wr_pending;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  nx_node_instr_store #(.RAM_ADDR_W(AW), .RAM_DATA_W(DW), .WR_FIFO_DEPTH(4), .NODE_PARAM_WIDTH(PW)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_rd_addr(rd_addr), .i_rd_en(rd_en), .o_rd_data(rd_data), .o_rd_stall(rd_stall),
    .o_populated(populated), .o_wr_pending(wr_pending)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic acc;
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      acc = rst_n && rd_en && !rd_stall;
      @(posedge clk);
      #2;
      if (acc) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_data: unexpected data %0h with empty scoreboard", rd_data);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    while (!wr_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!wr_ready) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout: ready stuck at %0d, required 1", wr_ready);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e, output int stalls);
    int n = 0;
    exp_q.push_back(e);
    rd_en   = 1'b1;
    rd_addr = a;
    stalls  = 0;
    @(negedge clk);
    while (rd_stall && n < 50) begin
      stalls++;
      n++;
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    if (rd_stall) begin
      checks++;
      errors++;
      $display("FAIL rd_timeout: stall stuck at %0d, required 0", rd_stall);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bg_cycle();
    @(negedge clk);
    if (rd_en && !rd_stall) exp_q.push_back(BG);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (wr_pending && n < 50) begin
      n++;
      tick();
    end
    chk("drain_pending", wr_pending, 0);
  endtask

  initial begin
    int st;
    int total;
    int idx;
    logic exp_stall [8];
    logic exp_ready [8];
    exp_stall = '{0, 0, 0, 0, 1, 0, 1, 0};
    exp_ready = '{1, 1, 1, 1, 0, 1, 0, 1};

    #12;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_stall", rd_stall, 0);
    chk("rst_populated", populated, 0);
    chk("rst_wr_pending", wr_pending, 0);
    tick();
    rst_n = 1'b1;

    // three writes, no reads
    push_wr(10'd0, 32'h11);
    push_wr(10'd1, 32'h22);
    push_wr(10'd2, 32'h33);
    chk("t1_pending_last", wr_pending, 1);
    tick();
    chk("t1_pending_done", wr_pending, 0);
    chk("t1_populated", populated, 3);
    do_read(10'd0, 32'h11, st); chk("t1_stall0", st, 0);
    do_read(10'd1, 32'h22, st); chk("t1_stall1", st, 0);
    do_read(10'd2, 32'h33, st); chk("t1_stall2", st, 0);
    rd_en = 1'b0;

    // preload and back-to-back reads
    for (int i = 0; i < 8; i++) push_wr(AW'(i), 32'h100 + i);
    push_wr(10'd200, BG);
    drain();
    chk("t2_populated", populated, 201);
    total = 0;
    for (int i = 0; i < 8; i++) begin
      do_read(AW'(i), 32'h100 + i, st);
      total += st;
    end
    rd_en = 1'b0;
    chk("t2_no_stalls", total, 0);

    // continuous reads while six writes arrive
    rd_en   = 1'b1;
    rd_addr = 10'd200;
    idx     = 0;
    for (int c = 0; c < 8; c++) begin
      wr_valid = (idx < 6);
      wr_addr  = AW'(40 + idx);
      wr_data  = 32'h4000 + idx;
      @(negedge clk);
      chk($sformatf("t3_stall_c%0d", c), rd_stall, exp_stall[c]);
      chk($sformatf("t3_ready_c%0d", c), wr_ready, exp_ready[c]);
      if (rd_en && !rd_stall) exp_q.push_back(BG);
      if (wr_valid && wr_ready) idx++;
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    chk("t3_pushed", idx, 6);
    chk("t3_full_ready", wr_ready, 0);
    drain();
    for (int i = 0; i < 6; i++) begin
      do_read(AW'(40 + i), 32'h4000 + i, st);
      chk("t3_readback_stall", st, 0);
    end
    rd_en = 1'b0;

    // two writes to one address, then read it
    rd_en    = 1'b1;
    rd_addr  = 10'd200;
    wr_valid = 1'b1;
    wr_addr  = 10'd5;
    wr_data  = 32'hAAAA;
    bg_cycle();
    wr_data  = 32'hBBBB;
    bg_cycle();
    wr_valid = 1'b0;
    do_read(10'd5, 32'hBBBB, st);
`ifdef NX_INSTR_STORE_BYPASS_EN
    chk("t4_stalls", st, 0);
`else
    chk("t4_stalls", st, 2);
`endif
    rd_en = 1'b0;
    drain();
    do_read(10'd5, 32'hBBBB, st);
    rd_en = 1'b0;
    chk("t4_ram_stall", st, 0);

    // top address populates without wrap
    push_wr(10'd1023, 32'hFFFF0001);
    drain();
    chk("t5_populated_top", populated, 1024);
    push_wr(10'd3, 32'h3333);
    drain();
    chk("t5_populated_hold", populated, 1024);
    do_read(10'd1023, 32'hFFFF0001, st);
    do_read(10'd3, 32'h3333, st);
    rd_en = 1'b0;

    // reset with buffered entries
    push_wr(10'd20, 32'h2020);
    drain();
    rd_en   = 1'b1;
    rd_addr = 10'd200;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(20 + i);
      wr_data  = 32'hDEAD0000 + i;
      bg_cycle();
    end
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    chk("t6_pending_pre", wr_pending, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_pending_rst", wr_pending, 0);
    chk("t6_populated_rst", populated, 0);
    chk("t6_ready_rst", wr_ready, 1);
    chk("t6_rd_data_rst", rd_data, 0);
    tick();
    rst_n = 1'b1;
    do_read(10'd20, 32'h2020, st);
    rd_en = 1'b0;
    chk("t6_read_stall", st, 0);
    tick();
    chk("t6_populated_after", populated, 0);
    chk("t6_pending_after", wr_pending, 0);

    tick();
    tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nx_node_instr_store.md
# nx_node_instr_store

Instruction store for a node: the responder side of the core's instruction-fetch interface. It accepts instruction writes from the node's loader through a small write buffer. It serves single-cycle-latency fetch reads from the core over one shared RAM port, raising a stall when the port cannot serve a read. It also tracks the populated instruction count that the core uses to bound its program counter.

## Interface
Parameters:
- RAM_ADDR_W, 10, instruction address width
- RAM_DATA_W, 32, instruction word width
- WR_FIFO_DEPTH, 4, write-buffer entries (power of two, ≥2)

Ports:
- i_clk  input  1  clock; all state on rising edge
- i_rst  input  1  reset, asynchronous, active-low
- i_wr_addr  input  RAM_ADDR_W  loader write address
- i_wr_data  input  RAM_DATA_W  loader write data
- i_wr_valid  input  1  loader write request
- o_wr_ready  output  1  write buffer can accept; transfer on valid && ready
- i_rd_addr  input  RAM_ADDR_W  fetch address from core
- i_rd_en  input  1  fetch request
- o_rd_data  output  RAM_DATA_W  fetched instruction, registered
- o_rd_stall  output  1  fetch not accepted this cycle; core holds address
- o_populated  output  NODE_PARAM_WIDTH  highest committed address + 1
- o_wr_pending  output  1  write buffer non-empty

## Operation
- Write buffer: FIFO of {addr, data}, depth WR_FIFO_DEPTH.
  - o_wr_ready = !full, derived from registered occupancy only.
  - A push and a pop in the same cycle are legal when the buffer is non-empty.
- RAM: single port, RAM_DATA_W × 2^RAM_ADDR_W. Contents are not reset.
- Port arbitration each cycle, first match wins:
  - full && i_rd_en: pop head into RAM; o_rd_stall = 1 (drain priority prevents write starvation).
  - i_rd_en && address hit on any buffered entry: see Configuration.
  - i_rd_en: read RAM[i_rd_addr]; o_rd_stall = 0.
  - otherwise, buffer non-empty: pop head into RAM.
  - otherwise: port idle.
- o_rd_stall is 0 whenever i_rd_en = 0.
- o_rd_data updates only on the cycle after an accepted read and otherwise holds its last value.
- o_populated: on each commit to RAM, becomes max(o_populated, addr + 1). It never decreases except on reset.
  - Requirement: NODE_PARAM_WIDTH ≥ RAM_ADDR_W + 1, so that address 2^RAM_ADDR_W − 1 yields 2^RAM_ADDR_W without wrap.
- Writes to the same address commit in arrival order; the last one wins.
- FIFO pointers are RAM-free registers and wrap modulo WR_FIFO_DEPTH. Occupancy is tracked with an extra bit so full and empty are unambiguous.
- Reset mid-operation discards buffered writes. o_wr_pending = 0 immediately.

## Timing
- Reset values: o_wr_ready = 1, o_rd_data = 0, o_rd_stall = 0, o_populated = 0, o_wr_pending = 0.
- Read latency: 1 cycle. An accepted read in cycle N presents data on o_rd_data in cycle N+1.
- o_rd_stall is combinational from i_rd_en, i_rd_addr and registered buffer state. It has no path from i_wr_valid.
- Write visibility:
  - A write pushed in cycle N is readable from RAM no earlier than cycle N+2 (commit in N+1 at the earliest).
  - A read in cycle N+1 to that address is a buffer hit.
- o_populated reflects a commit on the cycle after that commit.
- Back-to-back reads with an empty buffer: zero stalls, one word per cycle.
- Continuous reads with writes arriving: the buffer fills to full, then exactly one stall cycle occurs per drained entry while full.

## Configuration
- NX_INSTR_STORE_BYPASS_EN defined: a read hitting buffered entries is accepted with o_rd_stall = 0.
  - o_rd_data in the next cycle takes the youngest matching entry's data.
  - The RAM port is used to drain the head in that cycle instead.
- Not defined: a read hitting any buffered entry stalls (o_rd_stall = 1), and the head drains. This repeats until no entry matches, then the read proceeds from RAM.

## Test plan
- Reset, then write 0x11,0x22,0x33 to addresses 0,1,2 with no reads -> o_wr_pending falls after 3 drain cycles; o_populated = 3.
- Preload addresses 0..7, then issue reads 0..7 back to back -> no stalls; o_rd_data = preload words in cycles 1..8 after the first request.
- Hold i_rd_en = 1 continuously while pushing 6 writes (depth 4) -> o_wr_ready low when 4 entries are held; o_rd_stall high exactly on drain-while-full cycles; all 6 words land in RAM.
- Push addr 5 = 0xAAAA then addr 5 = 0xBBBB, then read addr 5 the next cycle:
  - with bypass: no stall, o_rd_data = 0xBBBB.
  - without bypass: stall 2 cycles, then o_rd_data = 0xBBBB.
- Write address 2^RAM_ADDR_W − 1, then address 3 -> o_populated = 2^RAM_ADDR_W, unchanged after the second write.
- Assert reset with 3 entries buffered -> o_wr_pending = 0 and o_populated = 0 asynchronously; after release, a read of a never-committed buffered address returns the pre-existing RAM content.
